// File: rtl/fip_pkg.sv
// rtl/fip_pkg.sv - shared Q-format types, limits and helpers for the fixed-point divider
package fip_pkg;

  localparam int INT_BITS  = 16;
  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fip_t;

  localparam fip_t FIP_MAX = 32'sh7FFF_FFFF;
  localparam fip_t FIP_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // 33-bit magnitude so that the most negative value maps to +2^31 exactly
  function automatic logic [32:0] fip_mag(input fip_t v);
    logic [32:0] x;
    x = {v[31], v};
    return v[31] ? (~x + 33'd1) : x;
  endfunction

endpackage

// File: rtl/fip_32_seq_div_if.sv
// rtl/fip_32_seq_div_if.sv - operand/result handshake bundle of the sequential divider
interface fip_32_seq_div_if;
  import fip_pkg::*;

  logic in_valid;
  logic in_ready;
  fip_t dividend;
  fip_t divisor;
  logic out_valid;
  logic out_ready;
  fip_t quotient;
  logic overflow;
  logic underflow;
  logic busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, underflow, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, underflow, busy
  );

endinterface

// File: rtl/fip_div_step.sv
// rtl/fip_div_step.sv - one combinational restoring-division step
module fip_div_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem_in,
  input  logic         num_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   trial;
  logic [W-1:0] diff;

  // rem_in < dvs keeps every kept difference inside W bits, so modular subtract is exact
  always_comb begin
    trial   = {rem_in, num_bit};
    diff    = trial[W-1:0] - dvs;
    q_bit   = (trial >= {1'b0, dvs});
    rem_out = q_bit ? diff : trial[W-1:0];
  end

endmodule

// File: rtl/fip_32_seq_div.sv
// rtl/fip_32_seq_div.sv - signed Q16.16 sequential divider, one quotient bit per cycle
module fip_32_seq_div #(
  parameter int INT_BITS  = fip_pkg::INT_BITS,
  parameter int FRAC_BITS = fip_pkg::FRAC_BITS
) (
  input  logic            clk,
  input  logic            reset,
  fip_32_seq_div_if.slave bus
);
  import fip_pkg::*;

  // numerator is |dividend| << FRAC_BITS, i.e. 32 + FRAC_BITS bits wide
  localparam int NUM_W = INT_BITS + 2 * FRAC_BITS;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);
  localparam logic [NUM_W-1:0] POS_LIM  = NUM_W'($unsigned(FIP_MAX));
  localparam logic [NUM_W-1:0] NEG_LIM  = NUM_W'($unsigned(FIP_MIN));

  div_state_t       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] nq;
  logic [32:0]      rem;
  logic [32:0]      dvs;
  logic             sign;
  fip_t             quotient_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             div_zero;
  logic [32:0]      dvd_mag;
  logic [32:0]      dvs_mag;
  logic [32:0]      rem_n;
  logic             q_bit;
  logic [NUM_W-1:0] mag;
  fip_t             res_q;
  logic             res_ovf;

  assign div_zero = (bus.divisor == '0);
  assign dvd_mag  = fip_mag(bus.dividend);
  assign dvs_mag  = fip_mag(bus.divisor);

  fip_div_step #(.W(33)) u_step (
    .rem_in  (rem),
    .num_bit (nq[NUM_W-1]),
    .dvs     (dvs),
    .rem_out (rem_n),
    .q_bit   (q_bit)
  );

  // nq shifts numerator bits out of the top while quotient bits enter at the bottom
  assign mag = {nq[NUM_W-2:0], q_bit};

  always_comb begin
    res_q   = '0;
    res_ovf = 1'b0;
    if (!sign) begin
      if (mag > POS_LIM) begin
        res_q   = FIP_MAX;
        res_ovf = 1'b1;
      end else begin
        res_q = fip_t'(mag[31:0]);
      end
    end else begin
      if (mag > NEG_LIM) begin
        res_q   = FIP_MIN;
        res_ovf = 1'b1;
      end else begin
        res_q = fip_t'(~mag[31:0] + 32'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_n = div_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt == LAST_CNT) state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      nq          <= '0;
      rem         <= '0;
      dvs         <= '0;
      sign        <= 1'b0;
      quotient_r  <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign        <= bus.dividend[31] ^ bus.divisor[31];
            dvs         <= dvs_mag;
            nq          <= NUM_W'({dvd_mag, {FRAC_BITS{1'b0}}});
            rem         <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= div_zero;
          end
        end
        CALC: begin
          rem <= rem_n;
          nq  <= mag;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            quotient_r <= res_q;
            overflow_r <= res_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule

// File: tb/tb_fip_32_seq_div.sv
// tb/tb_fip_32_seq_div.sv - directed and randomised checks of fip_32_seq_div against a scoreboard
module tb_fip_32_seq_div;
  import fip_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t scoreboard[$];

  fip_32_seq_div_if bus();

  fip_32_seq_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic ovf, input logic unf);
    exp_t e;
    e.q = q; e.ovf = ovf; e.unf = unf;
    return e;
  endfunction

  // reference: wide integer division of the shifted magnitudes, then saturate
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sbv, ma, mb, m;
    logic   neg;
    e = mk(32'h0, 1'b0, 1'b0);
    if (b == 32'h0) begin
      e.unf = 1'b1;
      return e;
    end
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    m   = (ma * 65536) / mb;
    neg = (sa < 0) != (sbv < 0);
    if (!neg) begin
      if (m > 64'sh7FFF_FFFF) e = mk(32'h7FFF_FFFF, 1'b1, 1'b0);
      else                    e.q = 32'(m);
    end else begin
      if (m > 64'sh8000_0000) e = mk(32'h8000_0000, 1'b1, 1'b0);
      else                    e.q = 32'(-m);
    end
    return e;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " in_ready"}, {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input int exp_lat, input int hold);
    int   lat;
    exp_t got;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.out_ready = 1'b0;
    scoreboard.push_back(e);
    @(posedge clk);
    lat = 1;
    #1;
    // junk operands and an early out_ready must be ignored while calculating
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); lat++; #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    got = scoreboard.pop_front();
    chk({tag, " quotient"}, {32'd0, bus.quotient}, {32'd0, got.q});
    chk({tag, " flags"}, {62'd0, bus.overflow, bus.underflow}, {62'd0, got.ovf, got.unf});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold"},
          {27'd0, bus.out_valid, bus.in_ready, bus.busy, bus.overflow, bus.underflow, bus.quotient},
          {27'd0, 1'b1, 1'b0, 1'b1, got.ovf, got.unf, got.q});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " release"}, {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset state",
        {26'd0, bus.in_ready, bus.out_valid, bus.busy, bus.quotient, bus.overflow, bus.underflow},
        {26'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("basic",     32'h0006_0000, 32'h0002_0000, mk(32'h0003_0000, 1'b0, 1'b0), 49, 0);
    do_op("trunc",     32'h0001_0000, 32'h0003_0000, mk(32'h0000_5555, 1'b0, 1'b0), 49, 0);
    do_op("neg",       32'hFFF8_8000, 32'h0002_8000, mk(32'hFFFD_0000, 1'b0, 1'b0), 49, 0);
    do_op("divzero",   32'h0005_0000, 32'h0000_0000, mk(32'h0000_0000, 1'b0, 1'b1), 1, 0);
    do_op("sat_pos",   32'h4000_0000, 32'h0000_0100, mk(32'h7FFF_FFFF, 1'b1, 1'b0), 49, 0);
    do_op("sat_neg",   32'hC000_0000, 32'h0000_0100, mk(32'h8000_0000, 1'b1, 1'b0), 49, 0);
    do_op("min_exact", 32'h8000_0000, 32'h0001_0000, mk(32'h8000_0000, 1'b0, 1'b0), 49, 0);
    do_op("min_neg1",  32'h8000_0000, 32'hFFFF_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0), 49, 0);
    do_op("zero_neg",  32'h0000_0000, 32'hFFFF_0000, mk(32'h0000_0000, 1'b0, 1'b0), 49, 0);
    do_op("backpress", 32'h0012_3456, 32'hFFFF_8000, model(32'h0012_3456, 32'hFFFF_8000), 49, 5);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      ra = $signed(ra) >>> $urandom_range(0, 24);
      rb = $urandom >> $urandom_range(0, 30);
      if (rb == 32'h0) rb = 32'h1;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      do_op("random", ra, rb, model(ra, rb), 49, 0);
    end

    // abort a division part-way through CALC with an asynchronous reset
    wait_ready("abort");
    bus.in_valid = 1'b1;
    bus.dividend = 32'h0006_0000;
    bus.divisor  = 32'h0002_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("abort busy", {63'd0, bus.busy}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort reset",
        {26'd0, bus.in_ready, bus.out_valid, bus.busy, bus.quotient, bus.overflow, bus.underflow},
        {26'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    do_op("after_abort", 32'h0006_0000, 32'h0002_0000, mk(32'h0003_0000, 1'b0, 1'b0), 49, 0);

    chk("scoreboard empty", 64'(scoreboard.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
